timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl.sv | 120 ++++++++++++
 tb/tb_timer_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Sequences an external timer through reload/run cycles for a host-requested number of expiries.
// All outputs are registered and update one clock after the inputs that cause them; there is no backpressure.
module timer_ctrl #(
    parameter int PERIOD_WIDTH = 8
) (
    input  logic                    clock_in,
    input  logic                    reset_in,
    input  logic                    go_in,
    input  logic                    stop_in,
    input  logic [PERIOD_WIDTH-1:0] periods_in,
    input  logic                    ack_in,
    input  logic                    expire_in,
    output logic                    timer_reset_out,
    output logic                    timer_start_out,
    output logic                    irq_out,
    output logic                    missed_out,
    output logic                    busy_out,
    output logic [PERIOD_WIDTH-1:0] count_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RELOAD = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state;
    logic [PERIOD_WIDTH-1:0] periods_q;
    logic                    expire_q;

    logic                    expire_rise;
    logic                    expiry;
    logic                    go_ok;
    logic [PERIOD_WIDTH-1:0] count_inc;

    // A level held high counts once; stop_in suppresses an expiry in the same cycle.
    assign expire_rise = expire_in & ~expire_q;
    assign expiry      = (state == RUN) & expire_rise & ~stop_in;
    assign go_ok       = (state == IDLE) & go_in & ~stop_in & (periods_in != '0);
    assign count_inc   = count_out + PERIOD_WIDTH'(1);

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            state           <= IDLE;
            periods_q       <= '0;
            expire_q        <= 1'b0;
            timer_reset_out <= 1'b1;
            timer_start_out <= 1'b0;
            irq_out         <= 1'b0;
            missed_out      <= 1'b0;
            busy_out        <= 1'b0;
            count_out       <= '0;
        end else begin
            expire_q        <= expire_in;
            timer_reset_out <= 1'b0;

            // A new expiry wins over a simultaneous acknowledge for irq_out.
            if (expiry) begin
                irq_out <= 1'b1;
                if (ack_in) begin
                    missed_out <= 1'b0;
                end else if (irq_out) begin
                    missed_out <= 1'b1;
                end
            end else if (ack_in) begin
                irq_out    <= 1'b0;
                missed_out <= 1'b0;
            end

            if (stop_in) begin
                state           <= IDLE;
                timer_start_out <= 1'b0;
                busy_out        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (go_ok) begin
                            state           <= RELOAD;
                            periods_q       <= periods_in;
                            count_out       <= '0;
                            timer_reset_out <= 1'b1;
                            timer_start_out <= 1'b0;
                            busy_out        <= 1'b1;
                        end
                    end
                    RELOAD: begin
                        state           <= RUN;
                        timer_start_out <= 1'b1;
                        busy_out        <= 1'b1;
                    end
                    RUN: begin
                        if (expiry) begin
                            count_out       <= count_inc;
                            timer_start_out <= 1'b0;
                            // >= keeps count_out from ever passing the latched period count.
                            if (count_inc >= periods_q) begin
                                state <= DONE;
                            end else begin
                                state           <= RELOAD;
                                timer_reset_out <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state           <= IDLE;
                        timer_start_out <= 1'b0;
                        busy_out        <= 1'b0;
                    end
                    default: begin
                        state           <= IDLE;
                        timer_start_out <= 1'b0;
                        busy_out        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_timer_ctrl;

    localparam int PW = 8;

    logic          clock_in = 1'b0;
    logic          reset_in = 1'b0;
    logic          go_in = 1'b0;
    logic          stop_in = 1'b0;
    logic [PW-1:0] periods_in = '0;
    logic          ack_in = 1'b0;
    logic          expire_in = 1'b0;
    logic          timer_reset_out;
    logic          timer_start_out;
    logic          irq_out;
    logic          missed_out;
    logic          busy_out;
    logic [PW-1:0] count_out;

    int tests = 0;
    int fails = 0;

    timer_ctrl #(.PERIOD_WIDTH(PW)) dut (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .go_in           (go_in),
        .stop_in         (stop_in),
        .periods_in      (periods_in),
        .ack_in          (ack_in),
        .expire_in       (expire_in),
        .timer_reset_out (timer_reset_out),
        .timer_start_out (timer_start_out),
        .irq_out         (irq_out),
        .missed_out      (missed_out),
        .busy_out        (busy_out),
        .count_out       (count_out)
    );

    always #5 clock_in = ~clock_in;

    // Reference model: a sequence is a list of phases (reload pulse, timer
    // running, one finishing cycle); count/target are plain integers.
    bit m_in_reset;
    bit m_reload_pulse;
    bit m_timer_running;
    bit m_finishing;
    bit m_irq;
    bit m_missed;
    bit m_last_expire;
    int m_count;
    int m_target;

    task automatic model_step(input logic r, input logic g, input logic s,
                              input logic a, input logic e, input logic [PW-1:0] p);
        bit rising;
        bit counted;
        bit active;
        rising        = e && !m_last_expire;
        m_last_expire = e;
        if (!r) begin
            m_in_reset      = 1'b1;
            m_reload_pulse  = 1'b0;
            m_timer_running = 1'b0;
            m_finishing     = 1'b0;
            m_irq           = 1'b0;
            m_missed        = 1'b0;
            m_last_expire   = 1'b0;
            m_count         = 0;
            m_target        = 0;
            return;
        end
        m_in_reset = 1'b0;
        counted = m_timer_running && rising && !s;
        if (counted) begin
            if (a)          m_missed = 1'b0;
            else if (m_irq) m_missed = 1'b1;
            m_irq = 1'b1;
        end else if (a) begin
            m_irq    = 1'b0;
            m_missed = 1'b0;
        end
        active = m_reload_pulse || m_timer_running || m_finishing;
        if (s) begin
            m_reload_pulse  = 1'b0;
            m_timer_running = 1'b0;
            m_finishing     = 1'b0;
        end else if (!active) begin
            if (g && p != 0) begin
                m_target       = int'(p);
                m_count        = 0;
                m_reload_pulse = 1'b1;
            end
        end else if (m_reload_pulse) begin
            m_reload_pulse  = 1'b0;
            m_timer_running = 1'b1;
        end else if (m_timer_running) begin
            if (counted) begin
                m_count         = m_count + 1;
                m_timer_running = 1'b0;
                if (m_count == m_target) m_finishing = 1'b1;
                else                     m_reload_pulse = 1'b1;
            end
        end else begin
            m_finishing = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic g, input logic s,
                        input logic a, input logic e, input logic [PW-1:0] p);
        reset_in   = r;
        go_in      = g;
        stop_in    = s;
        ack_in     = a;
        expire_in  = e;
        periods_in = p;
        @(posedge clock_in);
        model_step(r, g, s, a, e, p);
        #1;
        chk("timer_reset", 32'(timer_reset_out), 32'(m_in_reset || m_reload_pulse));
        chk("timer_start", 32'(timer_start_out), 32'(m_timer_running));
        chk("irq",         32'(irq_out),         32'(m_irq));
        chk("missed",      32'(missed_out),      32'(m_missed));
        chk("busy",        32'(busy_out),
            32'(m_reload_pulse || m_timer_running || m_finishing));
        chk("count",       32'(count_out),       32'(m_count));
    endtask

    // Shorthand for a plain cycle with only expire/ack driven.
    task automatic idle_tick(input logic a, input logic e);
        tick(1'b1, 1'b0, 1'b0, a, e, '0);
    endtask

    initial begin
        logic e_rand;

        // Reset state
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("rst_timer_reset", 32'(timer_reset_out), 32'd1);
        chk("rst_busy",        32'(busy_out),        32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle_tick(1'b0, 1'b0);
        chk("post_rst_timer_reset", 32'(timer_reset_out), 32'd0);

        // Three-period sequence with ack after each expiry
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
        chk("go_reload_pulse", 32'(timer_reset_out), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            idle_tick(1'b0, 1'b0);
            chk("run_start", 32'(timer_start_out), 32'd1);
            idle_tick(1'b0, 1'b1);
            chk("seq_count", 32'(count_out), 32'(k));
            chk("seq_irq",   32'(irq_out),   32'd1);
            idle_tick(1'b1, 1'b0);
            chk("seq_ack_irq",    32'(irq_out),    32'd0);
            chk("seq_ack_missed", 32'(missed_out), 32'd0);
        end
        chk("seq_done_idle", 32'(busy_out),  32'd0);
        chk("seq_count_hold", 32'(count_out), 32'd3);

        // go with periods 0 and go+stop together are both ignored
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("go_zero_busy", 32'(busy_out), 32'd0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
        chk("go_stop_busy", 32'(busy_out), 32'd0);

        // Level expiry held for 10 cycles counts once
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        idle_tick(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) idle_tick(1'b0, 1'b1);
        chk("level_count", 32'(count_out), 32'd1);
        idle_tick(1'b0, 1'b0);
        idle_tick(1'b0, 1'b1);
        chk("level_count2", 32'(count_out), 32'd2);
        chk("level_missed", 32'(missed_out), 32'd1);
        idle_tick(1'b1, 1'b0);
        idle_tick(1'b0, 1'b0);

        // Overrun: two expiries without ack
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
        idle_tick(1'b0, 1'b0);
        idle_tick(1'b0, 1'b1);
        idle_tick(1'b0, 1'b0);
        idle_tick(1'b0, 1'b1);
        chk("ovr_irq",    32'(irq_out),    32'd1);
        chk("ovr_missed", 32'(missed_out), 32'd1);
        idle_tick(1'b1, 1'b0);
        chk("ovr_ack_irq",    32'(irq_out),    32'd0);
        chk("ovr_ack_missed", 32'(missed_out), 32'd0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);

        // Abort at count 1 of 4
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
        idle_tick(1'b0, 1'b0);
        idle_tick(1'b0, 1'b1);
        idle_tick(1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk("abort_start", 32'(timer_start_out), 32'd0);
        chk("abort_busy",  32'(busy_out),        32'd0);
        chk("abort_count", 32'(count_out),       32'd1);
        chk("abort_irq",   32'(irq_out),         32'd1);
        for (int i = 0; i < 3; i++) begin
            idle_tick(1'b0, 1'b1);
            idle_tick(1'b0, 1'b0);
        end
        chk("abort_ignored", 32'(count_out), 32'd1);
        idle_tick(1'b1, 1'b0);

        // Reset mid-RUN, then go with periods 0
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        idle_tick(1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk("midrst_timer_reset", 32'(timer_reset_out), 32'd1);
        chk("midrst_start",       32'(timer_start_out), 32'd0);
        chk("midrst_count",       32'(count_out),       32'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("midrst_go0_busy", 32'(busy_out), 32'd0);

        // Randomized traffic against the model
        e_rand = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) e_rand = ~e_rand;
            tick(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 4) == 0),
                 e_rand,
                 PW'($urandom_range(0, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
